// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl
// Brief    : Multicycle MIPS control sequencer (fetch/decode/execute/mem/wb)
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl #(
    parameter int WAIT_LIMIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    input  logic        syscall_done,
    output logic        pc_write,
    output logic        ir_write,
    output logic        mem_req,
    output logic        mem_write,
    output logic        iord,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic        syscall_req,
    output logic        illegal,
    output logic        bus_error,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11,
        S_SYSCALL   = 4'd12,
        S_HALT      = 4'd13
    } state_t;

    localparam logic [5:0] c_op_special = 6'h00;
    localparam logic [5:0] c_op_j       = 6'h02;
    localparam logic [5:0] c_op_jal     = 6'h03;
    localparam logic [5:0] c_op_beq     = 6'h04;
    localparam logic [5:0] c_op_bne     = 6'h05;
    localparam logic [5:0] c_op_addi    = 6'h08;
    localparam logic [5:0] c_op_addiu   = 6'h09;
    localparam logic [5:0] c_op_ori     = 6'h0D;
    localparam logic [5:0] c_op_lui     = 6'h0F;
    localparam logic [5:0] c_op_lw      = 6'h23;
    localparam logic [5:0] c_op_sw      = 6'h2B;
    localparam logic [5:0] c_fn_jr      = 6'h08;
    localparam logic [5:0] c_fn_syscall = 6'h0C;
    localparam logic [5:0] c_fn_add     = 6'h20;
    localparam logic [5:0] c_fn_sub     = 6'h22;
    localparam logic [5:0] c_fn_and     = 6'h24;
    localparam logic [5:0] c_fn_or      = 6'h25;
    localparam logic [5:0] c_fn_slt     = 6'h2A;

    localparam int CNT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               illegal_q, illegal_d;
    logic               bus_error_q, bus_error_d;
    logic [5:0]         w_op;
    logic [5:0]         w_fn;
    logic               w_mem_state;
    logic               w_timeout;

    assign w_op        = instr[31:26];
    assign w_fn        = instr[5:0];
    assign w_mem_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                         (state_q == S_MEM_WRITE);

    // Timeout fires on the cycle whose stall would bring the count to the limit.
    generate
        if (WAIT_LIMIT > 0) begin : g_limit
            assign w_timeout = w_mem_state && !mem_ready &&
                               (wait_cnt_q == CNT_W'(WAIT_LIMIT - 1));
        end else begin : g_unlimited
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            wait_cnt_q  <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            illegal_q   <= illegal_d;
            bus_error_q <= bus_error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 2'd0;
        mem_to_reg  = 2'd0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'd0;
        alu_op      = 3'b000;
        pc_source   = 2'd0;
        syscall_req = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                alu_op    = 3'b010;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (w_timeout) begin
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
                alu_op    = 3'b010;
                if (instr == 32'd0) begin
                    state_d = S_FETCH;
                end else begin
                    case (w_op)
                        c_op_lw, c_op_sw:                      state_d = S_MEM_ADDR;
                        c_op_addi, c_op_addiu, c_op_ori, c_op_lui: state_d = S_I_EXEC;
                        c_op_beq, c_op_bne:                    state_d = S_BRANCH;
                        c_op_j, c_op_jal:                      state_d = S_JUMP;
                        c_op_special: begin
                            case (w_fn)
                                c_fn_add, c_fn_sub, c_fn_and,
                                c_fn_or, c_fn_slt: state_d = S_R_EXEC;
                                c_fn_jr:           state_d = S_JUMP;
                                c_fn_syscall:      state_d = S_SYSCALL;
                                default:           state_d = S_HALT;
                            endcase
                        end
                        default: state_d = S_HALT;
                    endcase
                end
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_op    = 3'b010;
                state_d   = (w_op == c_op_sw) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready)      state_d = S_MEM_WB;
                else if (w_timeout) state_d = S_HALT;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'd1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready)      state_d = S_FETCH;
                else if (w_timeout) state_d = S_HALT;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                case (w_fn)
                    c_fn_sub: alu_op = 3'b110;
                    c_fn_and: alu_op = 3'b000;
                    c_fn_or:  alu_op = 3'b001;
                    c_fn_slt: alu_op = 3'b111;
                    default:  alu_op = 3'b010;
                endcase
                state_d = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 2'd1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b110;
                pc_source = 2'd1;
                pc_write  = (w_op == c_op_bne) ? ~zero : zero;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = (w_op == c_op_special) ? 2'd3 : 2'd2;
                if (w_op == c_op_jal) begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'd2;
                    mem_to_reg = 2'd2;
                end
                state_d = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                case (w_op)
                    c_op_ori: alu_op = 3'b001;
                    c_op_lui: alu_op = 3'b011;
                    default:  alu_op = 3'b010;
                endcase
                state_d = S_I_WB;
            end
            S_I_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_SYSCALL: begin
                syscall_req = 1'b1;
                if (syscall_done) state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        // Strobes are forced low combinationally so a mid-cycle reset kills them at once.
        if (reset) begin
            pc_write    = 1'b0;
            ir_write    = 1'b0;
            mem_req     = 1'b0;
            mem_write   = 1'b0;
            iord        = 1'b0;
            reg_write   = 1'b0;
            reg_dst     = 2'd0;
            mem_to_reg  = 2'd0;
            alu_src_a   = 1'b0;
            alu_src_b   = 2'd0;
            alu_op      = 3'b000;
            pc_source   = 2'd0;
            syscall_req = 1'b0;
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (w_mem_state && !mem_ready) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
        illegal_d   = illegal_q | ((state_q == S_DECODE) && (state_d == S_HALT));
        bus_error_d = bus_error_q | w_timeout;
    end

    assign state     = state_q;
    assign illegal   = illegal_q;
    assign bus_error = bus_error_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multicycle_ctrl
// Brief    : Directed self-checking bench for mips_multicycle_ctrl
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_ctrl;

    logic        clk;
    logic        reset, zero, mem_ready, syscall_done;
    logic [31:0] instr;
    logic        pc_write, ir_write, mem_req, mem_write, iord, reg_write;
    logic [1:0]  reg_dst, mem_to_reg, alu_src_b, pc_source;
    logic        alu_src_a, syscall_req, illegal, bus_error;
    logic [2:0]  alu_op;
    logic [3:0]  state;

    logic        reset_b, zero_b, mem_ready_b, syscall_done_b;
    logic [31:0] instr_b;
    logic        pc_write_b, ir_write_b, mem_req_b, mem_write_b, iord_b, reg_write_b;
    logic [1:0]  reg_dst_b, mem_to_reg_b, alu_src_b_b, pc_source_b;
    logic        alu_src_a_b, syscall_req_b, illegal_b, bus_error_b;
    logic [2:0]  alu_op_b;
    logic [3:0]  state_b;

    int checks   = 0;
    int failures = 0;

    mips_multicycle_ctrl u_dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero),
        .mem_ready(mem_ready), .syscall_done(syscall_done),
        .pc_write(pc_write), .ir_write(ir_write), .mem_req(mem_req),
        .mem_write(mem_write), .iord(iord), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .syscall_req(syscall_req), .illegal(illegal), .bus_error(bus_error),
        .state(state)
    );

    mips_multicycle_ctrl #(.WAIT_LIMIT(4)) u_dut_wl (
        .clk(clk), .reset(reset_b), .instr(instr_b), .zero(zero_b),
        .mem_ready(mem_ready_b), .syscall_done(syscall_done_b),
        .pc_write(pc_write_b), .ir_write(ir_write_b), .mem_req(mem_req_b),
        .mem_write(mem_write_b), .iord(iord_b), .reg_write(reg_write_b),
        .reg_dst(reg_dst_b), .mem_to_reg(mem_to_reg_b), .alu_src_a(alu_src_a_b),
        .alu_src_b(alu_src_b_b), .alu_op(alu_op_b), .pc_source(pc_source_b),
        .syscall_req(syscall_req_b), .illegal(illegal_b), .bus_error(bus_error_b),
        .state(state_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Leaves the DUT in DECODE holding the given instruction.
    task automatic fetch_decode(input logic [31:0] ins);
        instr     = ins;
        mem_ready = 1'b1;
        #1;
        check_eq("fetch_state", {28'd0, state}, 32'd0);
        step();
        #1;
        check_eq("decode_state", {28'd0, state}, 32'd1);
    endtask

    task automatic run_rtype(input logic [31:0] ins, input logic [2:0] exp_op);
        fetch_decode(ins);
        step(); #1;
        check_eq("rexec_state", {28'd0, state}, 32'd6);
        check_eq("rexec_alu_op", {29'd0, alu_op}, {29'd0, exp_op});
        check_eq("rexec_srcs", {29'd0, alu_src_a, alu_src_b}, 32'b100);
        step(); #1;
        check_eq("rwb_ctrl", {27'd0, state, reg_write}, {27'd0, 4'd7, 1'b1});
        check_eq("rwb_reg_dst", {30'd0, reg_dst}, 32'd1);
        step(); #1;
        check_eq("rtype_done", {28'd0, state}, 32'd0);
    endtask

    task automatic run_branch(input logic [31:0] ins, input logic z, input logic exp_pcw);
        fetch_decode(ins);
        step();
        zero = z;
        #1;
        check_eq("branch_state", {28'd0, state}, 32'd8);
        check_eq("branch_pc_write", {31'd0, pc_write}, {31'd0, exp_pcw});
        check_eq("branch_pc_source", {30'd0, pc_source}, 32'd1);
        step();
        zero = 1'b0;
        #1;
        check_eq("branch_done", {28'd0, state}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; instr = '0; zero = 1'b0; mem_ready = 1'b0; syscall_done = 1'b0;
        reset_b = 1'b1; instr_b = '0; zero_b = 1'b0; mem_ready_b = 1'b0; syscall_done_b = 1'b0;
        #2;
        check_eq("reset_outputs",
                 {16'd0, mem_req, ir_write, pc_write, reg_write, alu_src_b, alu_op, state, illegal, bus_error},
                 32'd0);

        step();
        reset = 1'b0;
        #1;
        check_eq("fetch_after_reset",
                 {20'd0, state, mem_req, iord, alu_src_b, alu_op, ir_write},
                 {20'd0, 4'd0, 1'b1, 1'b0, 2'd1, 3'b010, 1'b0});

        // addi $t0,$zero,5
        instr = 32'h20080005;
        mem_ready = 1'b1;
        #1;
        check_eq("fetch_writes", {28'd0, ir_write, pc_write, pc_source}, 32'b1100);
        step(); #1;
        check_eq("addi_decode", {23'd0, state, alu_src_b, alu_op}, {23'd0, 4'd1, 2'd3, 3'b010});
        step(); #1;
        check_eq("addi_iexec", {22'd0, state, alu_src_a, alu_src_b, alu_op},
                 {22'd0, 4'd10, 1'b1, 2'd2, 3'b010});
        step(); #1;
        check_eq("addi_iwb", {21'd0, state, reg_write, reg_dst, mem_to_reg},
                 {21'd0, 4'd11, 1'b1, 2'd0, 2'd0});
        step(); #1;
        check_eq("addi_done", {28'd0, state}, 32'd0);

        // lw $t1,4($t0) with three wait cycles in MEM_READ
        fetch_decode(32'h8D090004);
        step(); #1;
        check_eq("lw_memaddr", {25'd0, state, alu_src_a, alu_src_b},
                 {25'd0, 4'd2, 1'b1, 2'd2});
        step();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("lw_memread_wait", {26'd0, state, mem_req, iord}, {26'd0, 4'd3, 2'b11});
            step();
        end
        mem_ready = 1'b1;
        #1;
        check_eq("lw_memread_last", {26'd0, state, mem_req, iord}, {26'd0, 4'd3, 2'b11});
        step(); #1;
        check_eq("lw_memwb", {25'd0, state, reg_write, mem_to_reg},
                 {25'd0, 4'd4, 1'b1, 2'd1});
        step(); #1;
        check_eq("lw_done", {28'd0, state}, 32'd0);

        run_rtype(32'h01095022, 3'b110);   // sub
        run_rtype(32'h0109502A, 3'b111);   // slt
        run_rtype(32'h01095024, 3'b000);   // and

        // lui $t0,0x1234
        fetch_decode(32'h3C081234);
        step(); #1;
        check_eq("lui_alu_op", {25'd0, state, alu_op}, {25'd0, 4'd10, 3'b011});
        step(); step(); #1;
        check_eq("lui_done", {28'd0, state}, 32'd0);

        run_branch(32'h10000002, 1'b1, 1'b1);
        run_branch(32'h10000002, 1'b0, 1'b0);
        run_branch(32'h14000002, 1'b1, 1'b0);

        // jal then jr $ra
        fetch_decode(32'h0C100000);
        step(); #1;
        check_eq("jal_jump", {21'd0, state, pc_write, pc_source, reg_write, reg_dst, mem_to_reg},
                 {21'd0, 4'd9, 1'b1, 2'd2, 1'b1, 2'd2, 2'd2});
        step(); #1;
        check_eq("jal_done", {28'd0, state}, 32'd0);
        fetch_decode(32'h03E00008);
        step(); #1;
        check_eq("jr_jump", {24'd0, state, pc_write, pc_source, reg_write},
                 {24'd0, 4'd9, 1'b1, 2'd3, 1'b0});
        step(); #1;
        check_eq("jr_done", {28'd0, state}, 32'd0);

        // NOP passes through DECODE without strobes
        fetch_decode(32'h00000000);
        check_eq("nop_quiet", {26'd0, reg_write, mem_req, pc_write, ir_write, mem_write, syscall_req}, 32'd0);
        step(); #1;
        check_eq("nop_done", {28'd0, state}, 32'd0);

        // syscall with handler finishing on the fifth cycle
        fetch_decode(32'h0000000C);
        step();
        for (int i = 0; i < 5; i++) begin
            syscall_done = (i == 4);
            #1;
            check_eq("syscall_wait", {27'd0, state, syscall_req}, {27'd0, 4'd12, 1'b1});
            step();
        end
        syscall_done = 1'b0;
        #1;
        check_eq("syscall_done", {27'd0, state, syscall_req}, {27'd0, 4'd0, 1'b0});

        // undecodable opcode 0x3F
        fetch_decode(32'hFC000000);
        step(); #1;
        check_eq("illegal_halt", {26'd0, state, illegal, bus_error}, {26'd0, 4'd13, 1'b1, 1'b0});
        repeat (20) step();
        #1;
        check_eq("illegal_stuck", {25'd0, state, illegal, mem_req, pc_write},
                 {25'd0, 4'd13, 1'b1, 1'b0, 1'b0});
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check_eq("illegal_cleared", {27'd0, state, illegal}, 32'd0);

        // sw, reset raised while MEM_WRITE is waiting
        fetch_decode(32'hAD090004);
        step(); #1;
        check_eq("sw_memaddr", {28'd0, state}, 32'd2);
        step();
        mem_ready = 1'b0;
        #1;
        check_eq("sw_memwrite", {25'd0, state, mem_req, mem_write, iord}, {25'd0, 4'd5, 3'b111});
        #1;
        reset = 1'b1;
        #1;
        check_eq("sw_reset_abort", {25'd0, state, mem_req, mem_write, iord}, 32'd0);
        step();
        reset = 1'b0;
        #1;
        check_eq("sw_restart", {27'd0, state, mem_req}, {27'd0, 4'd0, 1'b1});

        // WAIT_LIMIT=4 instance: memory never answers
        step();
        reset_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("wl_fetch_wait", {26'd0, state_b, mem_req_b, bus_error_b},
                     {26'd0, 4'd0, 1'b1, 1'b0});
            step();
        end
        #1;
        check_eq("wl_bus_error", {25'd0, state_b, bus_error_b, illegal_b, mem_req_b},
                 {25'd0, 4'd13, 1'b1, 1'b0, 1'b0});

        // mem_ready arriving on the limit cycle wins
        reset_b = 1'b1;
        step();
        reset_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_ready_b = (i == 3);
            #1;
            check_eq("wl_limit_fetch", {28'd0, state_b}, 32'd0);
            step();
        end
        mem_ready_b = 1'b0;
        #1;
        check_eq("wl_limit_ok", {27'd0, state_b, bus_error_b}, {27'd0, 4'd1, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

endmodule
`default_nettype wire

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multicycle sequencer for the MIPS datapath. It replaces the single-cycle decoder's one-shot control word with a state machine.
- Each instruction is stepped through fetch, decode, execute, memory and writeback. The block drives the PC, IR, memory, register-file, ALU-mux and syscall controls, one state per cycle.
- It stalls on memory and syscall handshakes.
- Opcode and funct encodings are taken from mips.h (`op`, `function` field macros).

Parameters:
- WAIT_LIMIT, 0, maximum cycles a memory state waits for mem_ready before bus error. 0 means unlimited.

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; state to FETCH, wait counter to 0
- instr  in  32  current IR contents
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current request this cycle
- syscall_done  in  1  syscall handler finished
- pc_write  out  1  load PC
- ir_write  out  1  load IR from memory data
- mem_req  out  1  memory request valid
- mem_write  out  1  request is a store
- iord  out  1  memory address: 0=PC, 1=ALUOut
- reg_write  out  1  register-file write enable
- reg_dst  out  2  0=rt, 1=rd, 2=$31
- mem_to_reg  out  2  0=ALUOut, 1=MDR, 2=PC
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  0=B, 1=const 4, 2=imm, 3=imm<<2
- alu_op  out  3  000 and, 001 or, 010 add, 011 lui, 110 sub, 111 slt
- pc_source  out  2  0=ALU result, 1=ALUOut, 2=jump target, 3=rs
- syscall_req  out  1  syscall pending
- illegal  out  1  undecodable instruction, sticky
- bus_error  out  1  memory timeout, sticky
- state  out  4  current state encoding, for debug

Behaviour:
- Outputs are Moore, decoded from state, plus instr/zero/mem_ready where noted. All outputs are 0 while reset is high.
- State encodings and actions:
  - FETCH (0): mem_req=1, iord=0, src_a=0, src_b=1, alu_op=010. On mem_ready, ir_write=1, pc_write=1, pc_source=0, go to DECODE; otherwise hold.
  - DECODE (1): src_a=0, src_b=3, alu_op=010 (branch target precompute). Transitions:
    - instr==0 (NOP) -> FETCH
    - LW/SW -> MEM_ADDR
    - SPECIAL ADD/SUB/AND/OR/SLT -> R_EXEC
    - SPECIAL JR -> JUMP
    - SPECIAL SYSCALL -> SYSCALL
    - ADDI/ADDIU/ORI/LUI -> I_EXEC
    - BEQ/BNE -> BRANCH
    - J/JAL -> JUMP
    - anything else -> HALT
  - MEM_ADDR (2): src_a=1, src_b=2, alu_op=010. LW -> MEM_READ, SW -> MEM_WRITE.
  - MEM_READ (3): mem_req=1, iord=1. Go to MEM_WB on mem_ready.
  - MEM_WB (4): reg_write=1, reg_dst=0, mem_to_reg=1. Then FETCH.
  - MEM_WRITE (5): mem_req=1, mem_write=1, iord=1. Go to FETCH on mem_ready.
  - R_EXEC (6): src_a=1, src_b=0, alu_op from funct (ADD 010, SUB 110, AND 000, OR 001, SLT 111). Then R_WB.
  - R_WB (7): reg_write=1, reg_dst=1, mem_to_reg=0. Then FETCH.
  - BRANCH (8): src_a=1, src_b=0, alu_op=110, pc_source=1. pc_write=zero for BEQ, ~zero for BNE. Then FETCH.
  - JUMP (9): pc_write=1. J: pc_source=2. JAL: pc_source=2, reg_write=1, reg_dst=2, mem_to_reg=2 (PC already +4). JR: pc_source=3, no register write. Then FETCH.
  - I_EXEC (10): src_a=1, src_b=2, alu_op ADDI/ADDIU 010, ORI 001, LUI 011. Then I_WB.
  - I_WB (11): reg_write=1, reg_dst=0, mem_to_reg=0. Then FETCH.
  - SYSCALL (12): syscall_req=1, held until syscall_done is sampled high, then FETCH. syscall_done outside SYSCALL is ignored.
  - HALT (13): terminal; all strobes 0. Only reset exits.
- Flags: illegal=1 if HALT was entered from DECODE. bus_error=1 if entered via timeout.
- Wait counter (memory states 0, 3, 5):
  - Clears on entry to each memory state; increments each cycle mem_ready is low.
  - If WAIT_LIMIT>0 and the counter reaches WAIT_LIMIT with mem_ready low, go to HALT with bus_error=1.
  - mem_ready high on the limit cycle wins: normal transition, no error.
- Instruction latency in cycles, with zero-wait memory:
  - LW 5
  - SW, R-type, I-type 4
  - branch, jump 3
  - NOP 2
  - syscall 3 + wait
- instr must be stable from DECODE through the last state of the instruction; the IR is only written in FETCH.
- Reset mid-instruction aborts immediately. No partial write is issued after reset rises.

Test Plan:
- Reset, then addi $t0,$zero,5 (0x20080005), mem_ready tied 1 -> states 0,1,10,11,0. I_WB shows reg_write=1, reg_dst=0, alu_op=010 in I_EXEC.
- lw $t1,4($t0) (0x8D090004), mem_ready low for 3 cycles in MEM_READ -> MEM_READ lasts 4 cycles with mem_req=1, iord=1, then MEM_WB with mem_to_reg=1. Total 8 cycles.
- beq (0x10000002) with zero=1 then zero=0, and bne (0x14000002) with zero=1 -> BRANCH pc_write is 1, 0 and 0 respectively, pc_source=1.
- jal (0x0C100000) -> JUMP with pc_write=1, pc_source=2, reg_write=1, reg_dst=2, mem_to_reg=2. jr $ra (0x03E00008) -> pc_source=3, reg_write=0.
- syscall (0x0000000C), syscall_done after 5 cycles -> syscall_req high exactly 5 cycles, then FETCH. Also 0x00000000 -> DECODE to FETCH with no strobes.
- Opcode 0x3F -> HALT with illegal=1, stuck for 20 cycles. WAIT_LIMIT=4 with mem_ready never high -> bus_error after 4 FETCH cycles. Reset asserted in MEM_WRITE -> mem_write drops the same cycle, restart at FETCH.
